inst_rom_arbiter: RTL and testbench

//  Shares the single-port combinational instruction ROM between the fetch stage (IF port)
//  and the memory stage's read-only data port (MEM port, e.g. constant-table loads).

---
 rtl/inst_rom_arbiter.sv | 148 ++++++++++++++
 tb/tb_inst_rom_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
// ============================================================================
// Module      : inst_rom_arbiter
// Description : Shares one combinational instruction ROM between the fetch
//               port and a read-only data port, with a one-cycle registered
//               response and a stall request for the pipeline controller.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_rom_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        stall_req
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESP_IF  = 2'd1,
    RESP_MEM = 2'd2,
    RESP_ERR = 2'd3
  } resp_state_e;

  localparam logic [CNT_W-1:0] c_starve_limit = CNT_W'(STARVE_LIMIT);

  resp_state_e      resp_state_q, resp_state_d;
  logic             err_with_if_q, err_with_if_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;
  logic             mem_err_q, mem_err_d;

  logic mem_misaligned;
  logic mem_rom_req;
  logic force_if;
  logic mem_rom_gnt;
  logic mem_bypass_gnt;
  logic if_take;

  // Arbitration: a misaligned MEM request never touches the ROM, so it is
  // always granted and leaves the ROM free for IF in the same cycle.
  always_comb begin
    mem_misaligned = |mem_addr[1:0];
    mem_rom_req    = mem_req & ~mem_misaligned;
    force_if       = if_req & mem_rom_req & (starve_cnt_q == c_starve_limit);
    if_gnt         = 1'b0;
    mem_gnt        = 1'b0;
    if (!rst) begin
      mem_gnt = mem_req & ~force_if;
      if_gnt  = if_req & ~(mem_rom_req & ~force_if);
    end
    mem_rom_gnt    = mem_gnt & ~mem_misaligned;
    mem_bypass_gnt = mem_gnt & mem_misaligned;
    rom_ce         = if_gnt | mem_rom_gnt;
    if (if_gnt) begin
      rom_addr = if_addr;
    end else if (mem_rom_gnt) begin
      rom_addr = mem_addr;
    end else begin
      rom_addr = 32'h0;
    end
    stall_req = ~rst & ((if_req & ~if_gnt) | (mem_req & ~mem_gnt));
  end

  always_comb begin
    if_take       = if_gnt & ~if_flush;
    starve_cnt_d  = starve_cnt_q;
    resp_state_d  = IDLE;
    err_with_if_d = 1'b0;
    if_rdata_d    = if_rdata_q;
    mem_rdata_d   = mem_rdata_q;
    mem_err_d     = mem_err_q;

    if (!if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (mem_rom_gnt && (starve_cnt_q < c_starve_limit)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    // The bypass response is the only MEM response that can share a cycle
    // with an IF response, so it rides along as a side flag.
    if (if_take) begin
      resp_state_d  = RESP_IF;
      err_with_if_d = mem_bypass_gnt;
    end else if (mem_rom_gnt) begin
      resp_state_d = RESP_MEM;
    end else if (mem_bypass_gnt) begin
      resp_state_d = RESP_ERR;
    end

    if (if_take) begin
      if_rdata_d = rom_inst;
    end
    if (mem_rom_gnt) begin
      mem_rdata_d = rom_inst;
      mem_err_d   = 1'b0;
    end else if (mem_bypass_gnt) begin
      mem_rdata_d = 32'h0;
      mem_err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_state_q  <= IDLE;
      err_with_if_q <= 1'b0;
      starve_cnt_q  <= '0;
      if_rdata_q    <= 32'h0;
      mem_rdata_q   <= 32'h0;
      mem_err_q     <= 1'b0;
    end else begin
      resp_state_q  <= resp_state_d;
      err_with_if_q <= err_with_if_d;
      starve_cnt_q  <= starve_cnt_d;
      if_rdata_q    <= if_rdata_d;
      mem_rdata_q   <= mem_rdata_d;
      mem_err_q     <= mem_err_d;
    end
  end

  // A response due while reset is asserted is dropped rather than presented.
  assign if_rvalid  = ~rst & (resp_state_q == RESP_IF);
  assign mem_rvalid = ~rst & ((resp_state_q == RESP_MEM) ||
                              (resp_state_q == RESP_ERR) || err_with_if_q);
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_err    = mem_err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_rom_arbiter.sv
// ============================================================================
// Module      : tb_inst_rom_arbiter
// Description : Directed and randomized bench for inst_rom_arbiter against a
//               cycle-level reference model of the arbitration rules.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_rom_arbiter;

  localparam int STARVE_LIMIT = 3;
  localparam int CNT_W        = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, mem_req;
  logic [31:0] if_addr, mem_addr;
  logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, mem_err, rom_ce, stall_req;
  logic [31:0] if_rdata, mem_rdata, rom_addr, rom_inst;

  int checks   = 0;
  int failures = 0;

  // Reference model state: expected registered outputs for the coming cycle.
  int          m_starve   = 0;
  bit          model_ok   = 0;
  logic        m_if_valid = 0, m_mem_valid = 0, m_mem_err = 0;
  logic [31:0] m_if_data  = 0, m_mem_data = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = {24'd0, a[9:2]};
    return idx * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  always_comb rom_inst = rom_ce ? rom_word(rom_addr) : 32'h0;

  inst_rom_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst), .stall_req(stall_req)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check everything visible in this cycle,
  // then advance the model to what the next cycle must present.
  task automatic cyc(input logic r, input logic ir, input logic [31:0] ia, input logic fl,
                     input logic mr, input logic [31:0] ma);
    logic mis, e_if, e_mem, e_rom_mem;
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia; if_flush = fl; mem_req = mr; mem_addr = ma;
    #1;
    mis   = (ma[1:0] != 2'b00);
    e_if  = 1'b0;
    e_mem = 1'b0;
    if (!r) begin
      if (mr && mis) begin
        e_mem = 1'b1;
        e_if  = ir;
      end else if (ir && mr) begin
        if (m_starve == STARVE_LIMIT) e_if = 1'b1;
        else e_mem = 1'b1;
      end else begin
        e_if  = ir;
        e_mem = mr;
      end
    end
    e_rom_mem = e_mem & ~mis;

    chk("if_gnt",    if_gnt,    e_if);
    chk("mem_gnt",   mem_gnt,   e_mem);
    chk("rom_ce",    rom_ce,    e_if | e_rom_mem);
    chk("rom_addr",  rom_addr,  e_if ? ia : (e_rom_mem ? ma : 32'h0));
    chk("stall_req", stall_req, r ? 1'b0 : ((ir & ~e_if) | (mr & ~e_mem)));
    if (model_ok) begin
      chk("if_rvalid",  if_rvalid,  m_if_valid & ~r);
      chk("if_rdata",   if_rdata,   m_if_data);
      chk("mem_rvalid", mem_rvalid, m_mem_valid & ~r);
      chk("mem_rdata",  mem_rdata,  m_mem_data);
      if (m_mem_valid && !r) chk("mem_err", mem_err, m_mem_err);
    end

    if (r) begin
      model_ok    = 1;
      m_starve    = 0;
      m_if_valid  = 0;
      m_mem_valid = 0;
      m_if_data   = 0;
      m_mem_data  = 0;
      m_mem_err   = 0;
    end else begin
      m_if_valid  = e_if & ~fl;
      if (m_if_valid) m_if_data = rom_word(ia);
      m_mem_valid = e_mem;
      if (e_mem) begin
        m_mem_data = mis ? 32'h0 : rom_word(ma);
        m_mem_err  = mis;
      end
      if (!ir || e_if) m_starve = 0;
      else if (e_rom_mem && m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic        r, ir, fl, mr;
    logic [31:0] ia, ma;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    mem_req = 1'b0; mem_addr = 32'h0;

    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 32'h8);
    idle();

    // IF alone, three consecutive words
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    idle();
    chk("t1_last_word", if_rdata, rom_word(32'h8));

    // MEM alone
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
    idle();

    // Both pending: starvation forcing (M,M,M,I,M,M)
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h44);
    idle();

    // Misaligned MEM alongside IF
    cyc(1'b0, 1'b1, 32'h20, 1'b0, 1'b1, 32'h6);
    idle();
    chk("t4_if_word", if_rdata, rom_word(32'h20));

    // Flushed fetch then a normal one
    cyc(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h34, 1'b0, 1'b0, 32'h0);
    idle();

    // Reset right after an IF grant, with starvation partly built up
    cyc(1'b0, 1'b1, 32'h50, 1'b0, 1'b1, 32'h54);
    cyc(1'b0, 1'b1, 32'h50, 1'b0, 1'b1, 32'h58);
    cyc(1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    chk("t6_if_rdata_reset", if_rdata, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h60, 1'b0, 1'b1, 32'h64);
    idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      ir = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 7) == 0);
      mr = ($urandom_range(0, 2) != 0);
      ia = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      ma = {22'd0, 8'($urandom_range(0, 255)),
            ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      cyc(r, ir, ia, fl, mr, ma);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
